// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and default sizes for the CPU data-memory path.
package cpu_pkg;

  localparam int WORD_W           = 32;
  localparam int DMEM_DEPTH_WORDS = 32;
  localparam int DMEM_ADDR_BITS   = 5;
  localparam int WAIT_CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word array with synchronous write, registered read and async clear.
// A write also drives its own data onto rdata, so a store echoes the stored word.
module dmem_array
  import cpu_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int ADDR_BITS   = DMEM_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] idx,
  input  logic [WORD_W-1:0]    wdata,
  output logic [WORD_W-1:0]    rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Storage: every word cleared by reset, one word written when we is high.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  // Read register: returns the addressed word, or the word being written.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rdata <= '0;
    end else if (we) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory target with programmable wait states.
// Optional feature macro: DMEM_ALIGN_CHECK_EN adds resp_err and blocks misaligned stores.
module dmem_responder
  import cpu_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int ADDR_BITS   = DMEM_ADDR_BITS,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic              resp_err,
`endif
  output logic              busy
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LIM = WAIT_CNT_W'(WAIT_CYCLES);

  dmem_state_t state, state_nxt;

  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  we_q;
  logic                  err_q;
  logic [ADDR_BITS-1:0]  idx_q;
  logic [WORD_W-1:0]     wdata_q;

  logic [ADDR_BITS-1:0]  req_idx;
  logic [ADDR_BITS-1:0]  arr_idx;
  logic [WORD_W-1:0]     arr_wdata;
  logic [WORD_W-1:0]     arr_rdata;
  logic                  arr_we;
  logic                  accept;
  logic                  misaligned;
  logic                  last_wait;
  logic                  unused_addr_bits;

  assign req_idx          = req_addr[ADDR_BITS+1:2];
  assign unused_addr_bits = ^{req_addr[WORD_W-1:ADDR_BITS+2], req_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = (req_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign accept    = (state == IDLE) && req_valid;
  assign last_wait = (state == WAIT) && (wait_cnt == WAIT_LIM);

  // State register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = (WAIT_LIM == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (last_wait) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; load data is only exposed while a response is held.
  always_comb begin
    req_ready  = (state == IDLE);
    busy       = (state != IDLE);
    resp_valid = (state == RESP);
    resp_rdata = '0;
    if ((state == RESP) && !err_q) begin
      resp_rdata = arr_rdata;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  // Misalignment flag is only visible alongside a response.
  always_comb begin
    resp_err = (state == RESP) && err_q;
  end
`endif

  // Wait counter: zero on entry to WAIT, counts up to WAIT_CYCLES, then clears.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wait_cnt <= '0;
    end else if ((state == WAIT) && !last_wait) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Request capture at acceptance; later input changes have no effect.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      err_q   <= misaligned;
      idx_q   <= req_idx;
      wdata_q <= req_wdata;
    end else if ((state == RESP) && resp_ready) begin
      err_q   <= 1'b0;
    end
  end

  // Array access: on the edge entering RESP, using live inputs when there are no wait states.
  always_comb begin
    arr_idx   = idx_q;
    arr_wdata = wdata_q;
    arr_we    = last_wait && we_q && !err_q;
    if (state == IDLE) begin
      arr_idx   = req_idx;
      arr_wdata = req_wdata;
      arr_we    = accept && (WAIT_LIM == '0) && req_we && !misaligned;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_BITS   (ADDR_BITS)
  ) u_array (
    .clk   (clk),
    .clrn  (clrn),
    .we    (arr_we),
    .idx   (arr_idx),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

endmodule
